n4_b2_integer_minmax_tracker: RTL

- Downstream consumer of n4_b2_integer_comparator. Accepts a burst of 4-bit two's-complement samples over a valid/ready handshake.
- Tracks the running maximum and minimum using two comparator instances. Presents the result on a held output until it is acknowledged.
- Sits after a sample source; feeds a result consumer such as a display or register file.

---
 rtl/n4_b2_integer_minmax_tracker_pkg.sv | 9 +
 rtl/n4_b2_integer_minmax_tracker_comparator.sv | 10 +
 rtl/n4_b2_integer_minmax_tracker.sv | 98 +++++++++
 3 files changed

// File: rtl/n4_b2_integer_minmax_tracker_pkg.sv
// n4_b2_integer_minmax_tracker_pkg: shared state encodings and burst-length constants
package n4_b2_integer_minmax_tracker_pkg;
    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACCUM  = 2'b01,
        REPORT = 2'b10
    } state_t;
    localparam logic [4:0] LEN_ZERO_COUNT = 5'd16;
endpackage

// File: rtl/n4_b2_integer_minmax_tracker_comparator.sv
// n4_b2_integer_comparator: signed 4-bit magnitude compare of a against b
module n4_b2_integer_comparator (
    input  logic [3:0] a3_a0,
    input  logic [3:0] b3_b0,
    output logic       flag_gr,
    output logic       flag_lr
);
    assign flag_gr = $signed(a3_a0) > $signed(b3_b0);
    assign flag_lr = $signed(a3_a0) < $signed(b3_b0);
endmodule

// File: rtl/n4_b2_integer_minmax_tracker.sv
// n4_b2_integer_minmax_tracker: running signed max/min over a handshaked burst
// MINMAX_INDEX_EN adds burst positions of the max/min samples
module n4_b2_integer_minmax_tracker
    import n4_b2_integer_minmax_tracker_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic [3:0] len3_len0,
    input  logic [3:0] x3_x0,
    input  logic       x_valid,
    output logic       x_ready,
    output logic [3:0] max3_max0,
    output logic [3:0] min3_min0,
    output logic       out_valid,
    input  logic       out_ack,
`ifdef MINMAX_INDEX_EN
    output logic [3:0] maxi3_maxi0,
    output logic [3:0] mini3_mini0,
`endif
    output logic       busy
);
    state_t     state, next_state;
    logic [4:0] cnt;
    logic       first;
    logic       xfer;
    logic       max_gr, min_lr;
    logic       unused_max_lr, unused_min_gr;

    n4_b2_integer_comparator u_cmp_max (
        .a3_a0  (x3_x0),
        .b3_b0  (max3_max0),
        .flag_gr(max_gr),
        .flag_lr(unused_max_lr)
    );

    n4_b2_integer_comparator u_cmp_min (
        .a3_a0  (x3_x0),
        .b3_b0  (min3_min0),
        .flag_gr(unused_min_gr),
        .flag_lr(min_lr)
    );

    assign x_ready   = state == ACCUM;
    assign out_valid = state == REPORT;
    assign busy      = state != IDLE;
    assign xfer      = x_valid && x_ready;

    always_comb begin
        next_state = IDLE;
        case (state)
            IDLE:    next_state = start ? ACCUM : IDLE;
            ACCUM:   next_state = (xfer && cnt == 5'd1) ? REPORT : ACCUM;
            REPORT:  next_state = out_ack ? IDLE : REPORT;
            default: next_state = IDLE;
        endcase
    end

`ifdef MINMAX_INDEX_EN
    logic [3:0] pos;
    always_ff @(posedge clock) begin
        if (reset) begin
            pos         <= '0;
            maxi3_maxi0 <= '0;
            mini3_mini0 <= '0;
        end else if (state == IDLE && start) begin
            pos <= '0;
        end else if (xfer) begin
            pos <= pos + 4'd1;
            if (first || max_gr) maxi3_maxi0 <= pos;
            if (first || min_lr) mini3_mini0 <= pos;
        end
    end
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            first     <= 1'b0;
            max3_max0 <= '0;
            min3_min0 <= '0;
        end else begin
            state <= next_state;
            if (state == IDLE && start) begin
                cnt   <= (len3_len0 == 4'd0) ? LEN_ZERO_COUNT : {1'b0, len3_len0};
                first <= 1'b1;
            end
            if (xfer) begin
                cnt   <= cnt - 5'd1;
                first <= 1'b0;
                // ties fail the strict compare, so the earliest sample holds
                if (first || max_gr) max3_max0 <= x3_x0;
                if (first || min_lr) min3_min0 <= x3_x0;
            end
        end
    end
endmodule
